// File: rtl/floo_vc_pkg.sv
// Shared definitions for the credit-based virtual-channel link (tx and rx ends).
package floo_vc_pkg;

   localparam int DefaultNumVirtChannels = 2;
   localparam int DefaultFifoDepth       = 4;

   // Sticky receive-side error flags.
   typedef struct packed {
      logic overflow;
      logic bad_vc;
   } rx_err_t;

   // Width of a VC identifier; a single-VC link still carries one id bit.
   function automatic int vc_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold 0..depth (occupancy or credits).
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/floo_vc_credit_rx_if.sv
// Link-side and router-side signals of the VC credit receiver.
// slave: the receiver; master: whoever drives the link and consumes the VCs.
interface floo_vc_credit_rx_if
   import floo_vc_pkg::*;
#(
   parameter int  NumVirtChannels = DefaultNumVirtChannels,
   parameter type flit_t          = logic
) ();

   localparam int VcIdWidth = vc_id_width(NumVirtChannels);

   logic                       valid_i;
   logic [VcIdWidth-1:0]       vc_id_i;
   flit_t                      data_i;
   logic [NumVirtChannels-1:0] credit_o;
   logic [NumVirtChannels-1:0] valid_o;
   logic [NumVirtChannels-1:0] ready_i;
   flit_t [NumVirtChannels-1:0] data_o;
   logic                       overflow_o;
   logic                       bad_vc_o;

   modport slave (
      input  valid_i, vc_id_i, data_i, ready_i,
      output credit_o, valid_o, data_o, overflow_o, bad_vc_o
   );

   modport master (
      output valid_i, vc_id_i, data_i, ready_i,
      input  credit_o, valid_o, data_o, overflow_o, bad_vc_o
   );

endinterface

// File: rtl/floo_vc_rx_fifo.sv
// One per-VC receive FIFO. The caller only asserts push when there is room
// (not full, or a pop in the same cycle frees the slot being written).
module floo_vc_rx_fifo
   import floo_vc_pkg::*;
#(
   parameter int  FifoDepth = DefaultFifoDepth,
   parameter type flit_t    = logic
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               push,
   input  logic                               pop,
   input  flit_t                              wdata,
   output flit_t                              data,
   output logic [credit_width(FifoDepth)-1:0] count,
   output logic                               full,
   output logic                               empty
);

   localparam int PtrWidth = $clog2(FifoDepth);
   localparam int CntWidth = credit_width(FifoDepth);

   flit_t               mem [FifoDepth];
   logic [PtrWidth-1:0] wptr;
   logic [PtrWidth-1:0] rptr;
   logic [CntWidth-1:0] cnt;

   // Pointers wrap at FifoDepth, which need not be a power of two.
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   // Pointer and occupancy bookkeeping; push+pop together keeps the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CntWidth'(1);
            2'b01:   cnt <= cnt - CntWidth'(1);
            default: ;
         endcase
      end
   end

   // Storage is cleared on reset so the head output reads zero afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wptr] <= wdata;
      end
   end

   assign data  = mem[rptr];
   assign count = cnt;
   assign full  = (cnt == CntWidth'(FifoDepth));
   assign empty = (cnt == '0);

endmodule

// File: rtl/floo_vc_credit_rx.sv
// Receive end of a credit-based VC link: steers incoming flits into per-VC
// FIFOs, presents each FIFO head downstream and returns one credit per pop.
module floo_vc_credit_rx
   import floo_vc_pkg::*;
#(
   parameter int  NumVirtChannels = DefaultNumVirtChannels,
   parameter int  FifoDepth       = DefaultFifoDepth,
   parameter type flit_t          = logic
) (
   input logic                clk_i,
   input logic                rst_i,
   floo_vc_credit_rx_if.slave bus
);

   localparam int VcIdWidth = vc_id_width(NumVirtChannels);
   localparam int CntWidth  = credit_width(FifoDepth);

   logic                        vc_legal;
   logic [NumVirtChannels-1:0]  push_req;
   logic [NumVirtChannels-1:0]  push_ok;
   logic [NumVirtChannels-1:0]  pop;
   logic [NumVirtChannels-1:0]  full;
   logic [NumVirtChannels-1:0]  empty;
   logic [NumVirtChannels-1:0]  credit_q;
   logic [CntWidth-1:0]         count [NumVirtChannels];
   flit_t [NumVirtChannels-1:0] head;
   rx_err_t                     err_q;

   // Ids beyond the VC count only exist when the count is not a power of two.
   if (NumVirtChannels == 1) begin : g_single
      assign vc_legal = 1'b1;
   end else begin : g_multi
      assign vc_legal = (int'(bus.vc_id_i) < NumVirtChannels);
   end

   for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
      localparam logic [VcIdWidth-1:0] VcIdx = VcIdWidth'(v);

      assign push_req[v] = bus.valid_i & vc_legal
                         & ((NumVirtChannels == 1) | (bus.vc_id_i == VcIdx));
      assign pop[v]      = ~empty[v] & bus.ready_i[v];
      // A full FIFO still takes a flit when its head leaves in the same cycle.
      assign push_ok[v]  = push_req[v] & (~full[v] | pop[v]);

      floo_vc_rx_fifo #(
         .FifoDepth (FifoDepth),
         .flit_t    (flit_t)
      ) i_fifo (
         .clk   (clk_i),
         .rst   (rst_i),
         .push  (push_ok[v]),
         .pop   (pop[v]),
         .wdata (bus.data_i),
         .data  (head[v]),
         .count (count[v]),
         .full  (full[v]),
         .empty (empty[v])
      );

      assign bus.valid_o[v] = ~empty[v];

      a_full_matches_count : assert property (@(posedge clk_i) disable iff (rst_i)
         full[v] == (count[v] == CntWidth'(FifoDepth)));
   end

   // One registered credit pulse per handshake, one cycle later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) credit_q <= '0;
      else       credit_q <= pop;
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= '0;
      end else begin
         if (|(push_req & ~push_ok))    err_q.overflow <= 1'b1;
         if (bus.valid_i & ~vc_legal)   err_q.bad_vc   <= 1'b1;
      end
   end

   assign bus.credit_o   = credit_q;
   assign bus.data_o     = head;
   assign bus.overflow_o = err_q.overflow;
   assign bus.bad_vc_o   = err_q.bad_vc;

endmodule

// File: tb/tb_floo_vc_credit_rx.sv
// Bench for floo_vc_credit_rx: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_floo_vc_credit_rx;

   localparam int NV = 2;
   localparam int D  = 4;
   typedef logic [7:0] flit_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   floo_vc_credit_rx_if #(.NumVirtChannels(NV), .flit_t(flit_t)) bus ();
   floo_vc_credit_rx_if #(.NumVirtChannels(3),  .flit_t(flit_t)) bus3 ();

   floo_vc_credit_rx #(.NumVirtChannels(NV), .FifoDepth(D), .flit_t(flit_t)) dut (
      .clk_i (clk), .rst_i (rst), .bus (bus)
   );

   floo_vc_credit_rx #(.NumVirtChannels(3), .FifoDepth(2), .flit_t(flit_t)) dut3 (
      .clk_i (clk), .rst_i (rst), .bus (bus3)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: one queue per VC, sticky overflow, credits of last cycle.
   flit_t      q0[$];
   flit_t      q1[$];
   logic       m_ovf;
   logic [1:0] m_credit;

   typedef struct {
      logic       v;
      logic       vc;
      flit_t      d;
      logic [1:0] rdy;
      logic [1:0] e_valid;
      logic [1:0] e_credit;
      logic       e_ovf;
      flit_t      e_d0;
      flit_t      e_d1;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic v, input logic vc, input flit_t d, input logic [1:0] rdy,
                               input logic [1:0] ev, input logic [1:0] ec, input logic eo,
                               input flit_t d0, input flit_t d1);
      vec_t r;
      r.v = v; r.vc = vc; r.d = d; r.rdy = rdy;
      r.e_valid = ev; r.e_credit = ec; r.e_ovf = eo; r.e_d0 = d0; r.e_d1 = d1;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_ovf    = 1'b0;
      m_credit = 2'b00;
   endtask

   // Pops happen on visible heads first; a pop frees a slot for this cycle's push.
   task automatic model_step(input logic v, input logic vc, input flit_t d, input logic [1:0] rdy);
      logic p0, p1;
      p0 = (q0.size() > 0) && rdy[0];
      p1 = (q1.size() > 0) && rdy[1];
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (v) begin
         if (vc == 1'b0) begin
            if (q0.size() < D) q0.push_back(d);
            else               m_ovf = 1'b1;
         end else begin
            if (q1.size() < D) q1.push_back(d);
            else               m_ovf = 1'b1;
         end
      end
      m_credit = {p1, p0};
   endtask

   task automatic drive(input logic v, input logic vc, input flit_t d, input logic [1:0] rdy);
      bus.valid_i = v;
      bus.vc_id_i = vc;
      bus.data_i  = d;
      bus.ready_i = rdy;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " valid"},    {30'd0, bus.valid_o}, {30'd0, q1.size() > 0, q0.size() > 0});
      chk({tag, " credit"},   {30'd0, bus.credit_o}, {30'd0, m_credit});
      chk({tag, " overflow"}, {31'd0, bus.overflow_o}, {31'd0, m_ovf});
      chk({tag, " bad_vc"},   {31'd0, bus.bad_vc_o}, 32'd0);
      if (q0.size() > 0) chk({tag, " data0"}, {24'd0, bus.data_o[0]}, {24'd0, q0[0]});
      if (q1.size() > 0) chk({tag, " data1"}, {24'd0, bus.data_o[1]}, {24'd0, q1[0]});
   endtask

   task automatic cycle(input logic v, input logic vc, input flit_t d, input logic [1:0] rdy,
                        input string tag);
      drive(v, vc, d, rdy);
      model_step(v, vc, d, rdy);
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 2'b00);
      bus3.valid_i = 1'b0;
      bus3.vc_id_i = 2'd0;
      bus3.data_i  = 8'h00;
      bus3.ready_i = 3'b000;
      model_reset();

      vecs[0]  = mk(1, 1, 8'hA5, 2'b11, 2'b10, 2'b00, 0, 8'h00, 8'hA5);
      vecs[1]  = mk(0, 0, 8'h00, 2'b11, 2'b00, 2'b10, 0, 8'h00, 8'h00);
      vecs[2]  = mk(0, 0, 8'h00, 2'b11, 2'b00, 2'b00, 0, 8'h00, 8'h00);
      vecs[3]  = mk(1, 0, 8'h01, 2'b00, 2'b01, 2'b00, 0, 8'h01, 8'h00);
      vecs[4]  = mk(1, 0, 8'h02, 2'b00, 2'b01, 2'b00, 0, 8'h01, 8'h00);
      vecs[5]  = mk(1, 0, 8'h03, 2'b00, 2'b01, 2'b00, 0, 8'h01, 8'h00);
      vecs[6]  = mk(1, 0, 8'h04, 2'b00, 2'b01, 2'b00, 0, 8'h01, 8'h00);
      vecs[7]  = mk(1, 0, 8'h55, 2'b00, 2'b01, 2'b00, 1, 8'h01, 8'h00);
      vecs[8]  = mk(1, 0, 8'h66, 2'b01, 2'b01, 2'b01, 1, 8'h02, 8'h00);
      vecs[9]  = mk(0, 0, 8'h00, 2'b01, 2'b01, 2'b01, 1, 8'h03, 8'h00);
      vecs[10] = mk(0, 0, 8'h00, 2'b01, 2'b01, 2'b01, 1, 8'h04, 8'h00);
      vecs[11] = mk(0, 0, 8'h00, 2'b01, 2'b01, 2'b01, 1, 8'h66, 8'h00);
      vecs[12] = mk(0, 0, 8'h00, 2'b01, 2'b00, 2'b01, 1, 8'h00, 8'h00);
      vecs[13] = mk(0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 8'h00, 8'h00);

      // Reset state
      @(posedge clk);
      @(negedge clk);
      chk("rst valid",    {30'd0, bus.valid_o}, 32'd0);
      chk("rst credit",   {30'd0, bus.credit_o}, 32'd0);
      chk("rst overflow", {31'd0, bus.overflow_o}, 32'd0);
      chk("rst bad_vc",   {31'd0, bus.bad_vc_o}, 32'd0);
      chk("rst data",     {16'd0, bus.data_o}, 32'd0);
      chk("rst3 bad_vc",  {31'd0, bus3.bad_vc_o}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table: single flit, fill, overflow, full push+pop, drain
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].v, vecs[i].vc, vecs[i].d, vecs[i].rdy);
         model_step(vecs[i].v, vecs[i].vc, vecs[i].d, vecs[i].rdy);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d valid", i),    {30'd0, bus.valid_o}, {30'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d credit", i),   {30'd0, bus.credit_o}, {30'd0, vecs[i].e_credit});
         chk($sformatf("vec%0d overflow", i), {31'd0, bus.overflow_o}, {31'd0, vecs[i].e_ovf});
         if (vecs[i].e_valid[0]) chk($sformatf("vec%0d data0", i), {24'd0, bus.data_o[0]}, {24'd0, vecs[i].e_d0});
         if (vecs[i].e_valid[1]) chk($sformatf("vec%0d data1", i), {24'd0, bus.data_o[1]}, {24'd0, vecs[i].e_d1});
      end

      // Illegal VC on a three-VC instance, then a legal push to VC2
      bus3.valid_i = 1'b1;
      bus3.vc_id_i = 2'd3;
      bus3.data_i  = 8'h77;
      @(posedge clk);
      @(negedge clk);
      chk("badvc flag",     {31'd0, bus3.bad_vc_o}, 32'd1);
      chk("badvc valid",    {29'd0, bus3.valid_o}, 32'd0);
      chk("badvc overflow", {31'd0, bus3.overflow_o}, 32'd0);
      bus3.vc_id_i = 2'd2;
      bus3.data_i  = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      bus3.valid_i = 1'b0;
      chk("vc2 valid",   {29'd0, bus3.valid_o}, 32'd4);
      chk("vc2 data",    {24'd0, bus3.data_o[2]}, 32'h3C);
      chk("vc2 bad_vc",  {31'd0, bus3.bad_vc_o}, 32'd1);

      // Interleaved VCs with VC1 stalled, then drain
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'(i % 2), flit_t'(8'h10 + i), 2'b01, "ilv");
      chk("ilv vc1 head stable", {24'd0, bus.data_o[1]}, 32'h11);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 2'b11, "ilv drain");

      // Randomized traffic with ready biased low so FIFOs fill up
      for (int i = 0; i < 600; i++) begin
         logic [1:0] r;
         r[0] = ($urandom_range(0, 2) == 0);
         r[1] = ($urandom_range(0, 2) == 0);
         cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), flit_t'($urandom), r, "rnd");
      end

      // Reset mid-traffic with flits buffered
      cycle(1'b1, 1'b0, 8'hA1, 2'b00, "pre_rst");
      rst = 1'b1;
      drive(1'b1, 1'b1, 8'hB1, 2'b11);
      #1;
      chk("in_rst valid",  {30'd0, bus.valid_o}, 32'd0);
      chk("in_rst credit", {30'd0, bus.credit_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("in_rst valid2",    {30'd0, bus.valid_o}, 32'd0);
      chk("in_rst credit2",   {30'd0, bus.credit_o}, 32'd0);
      chk("in_rst overflow",  {31'd0, bus.overflow_o}, 32'd0);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 2'b11, "post_rst");
      cycle(1'b1, 1'b1, 8'hC3, 2'b00, "post_rst push");
      chk("post_rst data1", {24'd0, bus.data_o[1]}, 32'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/floo_vc_credit_rx.md
Name: floo_vc_credit_rx

Overview:
- Receive end of a credit-based virtual-channel link. Counterpart of the transmitter that arbitrates per-VC flits onto one physical channel.
- Accepts one tagged flit per cycle from the physical link and steers it into a per-VC FIFO.
- Presents per-VC valid/ready/data to the downstream router port.
- Returns one credit per popped flit, so the remote transmitter never overruns a FIFO.

Parameters:
- NumVirtChannels, 2, number of virtual channels; must be >= 1.
- FifoDepth, 4, entries per VC FIFO; must be >= 2. This is also the initial credit count the transmitter must assume per VC.
- flit_t, logic, flit payload type.
- VcIdWidth, derived, max(1, $clog2(NumVirtChannels)); not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- valid_i  in  1  flit present on the physical link this cycle. No ready: flow control is by credits only.
- vc_id_i  in  VcIdWidth  target VC of the incoming flit.
- data_i  in  flit_t  incoming flit.
- credit_o  out  NumVirtChannels  per-VC credit-return pulse, one cycle per freed entry.
- valid_o  out  NumVirtChannels  per-VC head flit valid.
- ready_i  in  NumVirtChannels  per-VC downstream ready.
- data_o  out  [NumVirtChannels] flit_t  per-VC head flit.
- overflow_o  out  1  sticky error: a flit arrived for a full FIFO.
- bad_vc_o  out  1  sticky error: vc_id_i >= NumVirtChannels while valid_i is high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All FIFOs empty.
  - valid_o = 0, credit_o = 0, overflow_o = 0, bad_vc_o = 0.
  - data_o = '0.
- Push:
  - On valid_i=1 with a legal vc_id_i, the flit is written to FIFO[vc_id_i] at the clock edge.
  - Earliest visibility is valid_o[vc] = 1 in the next cycle; no combinational input-to-output path.
- Pop:
  - valid_o[v] & ready_i[v] removes the head of FIFO[v].
  - data_o[v] must hold stable while valid_o[v]=1 and ready_i[v]=0.
  - valid_o[v] must not drop without a handshake.
  - FIFOs are FIFO-ordered per VC. There is no ordering guarantee across VCs.
- Credit return:
  - credit_o[v] is a registered pulse asserted in cycle N+1 for each handshake on VC v in cycle N.
  - Exactly one pulse per popped flit, never merged; multiple VCs may pulse in the same cycle.
- Full boundary:
  - A push to a FIFO with count == FifoDepth is accepted only if the same VC pops in the same cycle; count stays at FifoDepth.
  - Otherwise the flit is dropped, FIFO contents are untouched, and overflow_o is set and held until reset.
- Empty boundary:
  - No bypass. A push into an empty FIFO is not visible in the same cycle.
  - Simultaneous push and pop on a FIFO with count == 1 leaves count = 1, with the new flit at the head.
- Illegal VC:
  - Applies only when NumVirtChannels is not a power of two.
  - Flit is dropped, bad_vc_o is set and held, and no FIFO changes.
- Pointers: read/write pointers wrap modulo FifoDepth; FifoDepth need not be a power of two. Occupancy counter is $clog2(FifoDepth+1) bits.
- Reset mid-operation:
  - All buffered flits are discarded and no credits are emitted for them.
  - The transmitter is required to be reset in the same domain so that its credit counters return to FifoDepth.
- NumVirtChannels == 1: vc_id_i is ignored and bad_vc_o stays 0.

Decomposition:
- Package floo_vc_pkg holds:
  - vc_id_width(n) function.
  - Credit-width helper.
  - Shared VC-count constants used by the transmitter and this receiver.
- Sub-module floo_vc_rx_fifo provides one per-VC FIFO:
  - Parameters: FifoDepth, flit_t.
  - Ports: push, pop, data, count, full, empty.
  - Instantiated NumVirtChannels times.
- The top level holds the push demux, the credit pulse register and the sticky error flags.

Test Plan:
- Single flit: reset; push VC1 data 0xA5 in cycle 3 with ready_i=2'b11 -> valid_o=2'b10 and data_o[1]=0xA5 in cycle 4; credit_o=2'b10 in cycle 5 only.
- Fill to depth: ready_i=0; push 4 flits 1..4 to VC0 -> valid_o[0] stays 1 with data 1, overflow_o=0. Release ready -> data 1,2,3,4 in order and four single-cycle credit_o[0] pulses.
- Overflow: with VC0 full and ready_i[0]=0, push 0x55 to VC0 -> dropped, overflow_o=1 next cycle and stays 1. Drain yields only the original 4 flits.
- Full push+pop: VC0 full, ready_i[0]=1, push 0x66 in the same cycle -> accepted, no overflow, 0x66 drained last, exactly one credit pulse for the pop.
- Interleaved VCs with stall: alternate pushes VC0/VC1 while ready_i[1]=0 -> VC0 drains normally with its credits, VC1 holds stable data; no cross-VC reordering of either stream.
- Reset mid-traffic: assert rst_i with 3 flits buffered -> valid_o=0 and credit_o=0 during and after reset, no credit pulses for flushed flits, sticky flags cleared.
